// File: rtl/leglite_bus_tracer.sv
// Trace recorder for the LEGLite CPU: snoops instruction and data buses into a
// circular buffer, stops a programmable number of samples after a trigger.
module leglite_bus_tracer #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int PW        = 4,
  parameter int POST_TRIG = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [AW-1:0]            iaddr,
  input  logic [DW-1:0]            idata,
  input  logic [AW-1:0]            draddr,
  input  logic [DW-1:0]            dwdata,
  input  logic [DW-1:0]            drdata,
  input  logic                     dwrite,
  input  logic                     dread,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [1:0]               trig_mode,
  input  logic [AW-1:0]            trig_addr,
  input  logic                     rd_en,
  input  logic [PW-1:0]            rd_idx,
  output logic [2+2*AW+2*DW-1:0]   rd_data,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic [PW:0]              fill,
  output logic [PW-1:0]            trig_pos,
  output logic                     done
);

  localparam int SW = 2 + 2*AW + 2*DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW:0] POST_W  = (PW+1)'(POST_TRIG);

  logic [SW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW:0]   post_left;

  logic [DW-1:0] dval;
  logic [SW-1:0] sample;
  logic          trig_hit;
  logic          write_en;
  logic [PW:0]   fill_inc;
  logic [PW:0]   trig_diff;
  logic [PW-1:0] rd_ptr;

  assign dval      = dwrite ? dwdata : drdata;
  assign sample    = {dwrite, dread, iaddr, idata, draddr, dval};
  assign fill_inc  = (fill == DEPTH_W) ? fill : fill + 1'b1;
  assign trig_diff = fill_inc - POST_W;
  assign rd_ptr    = wr_ptr - fill[PW-1:0] + rd_idx;
  assign write_en  = reset && !abort && (state == S_ARMED || state == S_POST);
  assign done      = (state == S_DONE);

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (iaddr == trig_addr);
      2'd2:    trig_hit = dwrite && (draddr == trig_addr);
      default: trig_hit = dread && (draddr == trig_addr);
    endcase
  end

  // Trace RAM is left uninitialised so it can map onto block memory.
  always_ff @(posedge clock) begin
    if (write_en)
      mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      post_left <= '0;
      trig_pos  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      fill      <= '0;
      post_left <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state     <= S_ARMED;
            wr_ptr    <= '0;
            fill      <= '0;
            post_left <= '0;
          end
        end
        S_ARMED: begin
          wr_ptr <= wr_ptr + 1'b1;
          fill   <= fill_inc;
          if (trig_hit) begin
            if (POST_TRIG == 1) begin
              state    <= S_DONE;
              trig_pos <= trig_diff[PW-1:0];
            end else begin
              state     <= S_POST;
              post_left <= POST_W - 1'b1;
            end
          end
        end
        default: begin
          // The write made while one post sample remains closes the capture.
          wr_ptr    <= wr_ptr + 1'b1;
          fill      <= fill_inc;
          post_left <= post_left - 1'b1;
          if (post_left == 1) begin
            state    <= S_DONE;
            trig_pos <= trig_diff[PW-1:0];
          end
        end
      endcase
    end
  end

  // Index 0 is the oldest stored entry; indices past fill read as zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (state == S_DONE && rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= ({1'b0, rd_idx} < fill) ? mem[rd_ptr] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leglite_bus_tracer.sv
// Directed bench for leglite_bus_tracer: a CPU whose PC steps by 2 each clock,
// with hand-computed expectations checked by immediate assertions.
module tb_leglite_bus_tracer;

  logic        clock;
  logic        reset;
  logic [15:0] iaddr, idata, draddr, dwdata, drdata;
  logic        dwrite, dread, arm, abort;
  logic [1:0]  trig_mode;
  logic [15:0] trig_addr;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic [65:0] rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic [4:0]  fill;
  logic [3:0]  trig_pos;
  logic        done;
  logic        pc_run;

  int checks;
  int errors;

  leglite_bus_tracer #(.AW(16), .DW(16), .DEPTH(16), .PW(4), .POST_TRIG(8)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata), .draddr(draddr),
    .dwdata(dwdata), .drdata(drdata), .dwrite(dwrite), .dread(dread), .arm(arm),
    .abort(abort), .trig_mode(trig_mode), .trig_addr(trig_addr), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
    .fill(fill), .trig_pos(trig_pos), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; the model CPU advances its PC just after the edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    if (pc_run) iaddr = iaddr + 16'd2;
    idata = iaddr ^ 16'h1234;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic readEntry(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    applyStimulus();
    rd_en  = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; iaddr = 16'h0; idata = 16'h1234; draddr = 16'h0;
    dwdata = 16'h0; drdata = 16'h0; dwrite = 1'b0; dread = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_mode = 2'd0; trig_addr = 16'h0;
    rd_en = 1'b0; rd_idx = 4'd0; pc_run = 1'b0;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_state", state, 2'd0);
    checkOutput("rst_fill", fill, 5'd0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_rd_valid", rd_valid, 1'b0);
    checkOutput("rst_rd_data", rd_data, 66'd0);
    reset = 1'b1;

    // Immediate trigger, armed with PC at 0x0000
    $display("[TB] immediate trigger");
    trig_mode = 2'd0; iaddr = 16'h0000; idata = iaddr ^ 16'h1234; pc_run = 1'b1;
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    checkOutput("imm_armed", state, 2'd1);
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("imm_post_before_end", state, 2'd2);
    applyStimulus();
    checkOutput("imm_done", done, 1'b1);
    checkOutput("imm_fill", fill, 5'd8);
    checkOutput("imm_trig_pos", trig_pos, 4'd0);
    readEntry(4'd0);
    checkOutput("imm_rd_valid", rd_valid, 1'b1);
    checkOutput("imm_idx0_iaddr", rd_data[63:48], 16'h0002);
    readEntry(4'd7);
    checkOutput("imm_idx7_iaddr", rd_data[63:48], 16'h0010);
    checkOutput("imm_idx7_idata", rd_data[47:32], 16'h0010 ^ 16'h1234);
    readEntry(4'd8);
    checkOutput("imm_idx8_valid", rd_valid, 1'b1);
    checkOutput("imm_idx8_zero", rd_data, 66'd0);
    readEntry(4'd1);
    applyStimulus();
    checkOutput("imm_rd_valid_drop", rd_valid, 1'b0);
    checkOutput("imm_rd_data_hold", rd_data[63:48], 16'h0004);

    // PC match trigger with buffer wrap
    $display("[TB] iaddr trigger with wrap");
    trig_mode = 2'd1; trig_addr = 16'h0020;
    iaddr = 16'hFFFE; idata = iaddr ^ 16'h1234;
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    for (int i = 0; i < 23; i++) applyStimulus();
    checkOutput("pc_not_done_23", done, 1'b0);
    applyStimulus();
    checkOutput("pc_done_24", done, 1'b1);
    checkOutput("pc_fill", fill, 5'd16);
    checkOutput("pc_trig_pos", trig_pos, 4'd8);
    readEntry(4'd0);
    checkOutput("pc_idx0_iaddr", rd_data[63:48], 16'h0010);
    readEntry(4'd8);
    checkOutput("pc_idx8_iaddr", rd_data[63:48], 16'h0020);
    checkOutput("pc_idx8_idata", rd_data[47:32], 16'h0020 ^ 16'h1234);
    readEntry(4'd15);
    checkOutput("pc_idx15_iaddr", rd_data[63:48], 16'h002E);

    // Store trigger; other stores and loads to the address do not fire
    $display("[TB] store trigger");
    trig_mode = 2'd2; trig_addr = 16'h0004;
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    dwrite = 1'b1; draddr = 16'h0008; dwdata = 16'h0011;
    applyStimulus();
    dwrite = 1'b0; dread = 1'b1; draddr = 16'h0004; drdata = 16'h0077;
    applyStimulus();
    checkOutput("st_no_false_trig", state, 2'd1);
    dwrite = 1'b1; dread = 1'b0; draddr = 16'h0004; dwdata = 16'h0055; drdata = 16'h0;
    applyStimulus();
    checkOutput("st_post", state, 2'd2);
    dwrite = 1'b0; draddr = 16'h0000; dwdata = 16'h0;
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("st_done", done, 1'b1);
    checkOutput("st_fill", fill, 5'd10);
    checkOutput("st_trig_pos", trig_pos, 4'd2);
    readEntry(4'd2);
    checkOutput("st_trig_enables", rd_data[65:64], 2'b10);
    checkOutput("st_trig_draddr", rd_data[31:16], 16'h0004);
    checkOutput("st_trig_dval", rd_data[15:0], 16'h0055);
    readEntry(4'd1);
    checkOutput("st_load_enables", rd_data[65:64], 2'b01);
    checkOutput("st_load_dval", rd_data[15:0], 16'h0077);

    // Abort during POST, then arm+abort together from IDLE
    $display("[TB] abort");
    trig_mode = 2'd0;
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("ab_in_post", state, 2'd2);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("ab_state", state, 2'd0);
    checkOutput("ab_fill", fill, 5'd0);
    checkOutput("ab_done", done, 1'b0);
    arm = 1'b1; abort = 1'b1;
    applyStimulus();
    arm = 1'b0; abort = 1'b0;
    checkOutput("ab_arm_same_cycle", state, 2'd0);

    // Reset mid-POST, then a fresh capture
    $display("[TB] reset mid-capture");
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    checkOutput("rm_state", state, 2'd0);
    checkOutput("rm_fill", fill, 5'd0);
    iaddr = 16'h0100; idata = iaddr ^ 16'h1234;
    arm = 1'b1;
    applyStimulus();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("rm_done", done, 1'b1);
    checkOutput("rm_fill8", fill, 5'd8);
    readEntry(4'd0);
    checkOutput("rm_idx0_iaddr", rd_data[63:48], 16'h0102);
    readEntry(4'd7);
    checkOutput("rm_idx7_iaddr", rd_data[63:48], 16'h0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
